// File: rtl/mem_write_buffer_pkg.sv
// Shared widths and the entry record layout for the MEM-stage store buffer.
package mem_write_buffer_pkg;

  localparam int unsigned WB_DEPTH = 4;
  localparam int unsigned WB_AW    = 10;
  localparam int unsigned WB_DW    = 32;
  localparam int unsigned WB_PCW   = 32;

  typedef struct packed {
    logic [WB_PCW-1:0] pc;
    logic [WB_AW-1:0]  addr;
    logic [WB_DW-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/mem_write_buffer_fwd_match.sv
// Store-to-load forwarding search: finds the youngest valid entry whose address matches the load.
module wb_fwd_match
  import mem_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH,
  parameter int unsigned AW    = WB_AW,
  parameter int unsigned DW    = WB_DW
) (
  input  logic [AW-1:0]              entry_addr [DEPTH],
  input  logic [DW-1:0]              entry_data [DEPTH],
  input  logic [DEPTH-1:0]           valid,
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic [AW-1:0]              ld_addr,
  output logic                       hit,
  output logic [DW-1:0]              data
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk from oldest to youngest so the last match found wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = PW'(head + PW'(i));
      if (valid[idx] && (entry_addr[idx] == ld_addr)) begin
        hit  = 1'b1;
        data = entry_data[idx];
      end
    end
  end

endmodule

// File: rtl/mem_write_buffer.sv
// In-order store buffer between the MEM-stage store path and data memory, with load forwarding.
module mem_write_buffer
  import mem_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH,
  parameter int unsigned AW    = WB_AW,
  parameter int unsigned DW    = WB_DW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  input  logic [WB_PCW-1:0] st_pc,
  input  logic [AW-1:0]     st_addr,
  input  logic [DW-1:0]     st_data,
  output logic              st_ready,
  input  logic              drain_en,
  input  logic [AW-1:0]     ld_addr,
  output logic              ld_hit,
  output logic [DW-1:0]     ld_data,
  output logic [WB_PCW-1:0] dm_pc,
  output logic              dm_we,
  output logic [AW-1:0]     dm_addr,
  output logic [DW-1:0]     dm_din,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WB_PCW-1:0] pc_mem   [DEPTH];
  logic [AW-1:0]     addr_mem [DEPTH];
  logic [DW-1:0]     data_mem [DEPTH];

  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic             push;
  logic [DEPTH-1:0] valid;

  // Status is decoded from registered count only, so st_ready has no input-to-output path.
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign st_ready = ~full;
  assign overflow = overflow_q;

  assign push  = st_valid & ~full;
  assign dm_we = drain_en & ~empty;

  assign dm_pc   = empty ? '0 : pc_mem[head_q];
  assign dm_addr = empty ? '0 : addr_mem[head_q];
  assign dm_din  = empty ? '0 : data_mem[head_q];

  // An entry is live when its distance from head is below count.
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = (CW'(PW'(PW'(i) - head_q)) < count_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        tail_q <= PW'(tail_q + PW'(1));
      end
      if (dm_we) begin
        head_q <= PW'(head_q + PW'(1));
      end
      case ({push, dm_we})
        2'b10:   count_q <= CW'(count_q + CW'(1));
        2'b01:   count_q <= CW'(count_q - CW'(1));
        default: count_q <= count_q;
      endcase
      if (st_valid && full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Payload needs no reset; validity is tracked by head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]   <= st_pc;
      addr_mem[tail_q] <= st_addr;
      data_mem[tail_q] <= st_data;
    end
  end

  wb_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd (
    .entry_addr (addr_mem),
    .entry_data (data_mem),
    .valid      (valid),
    .head       (head_q),
    .ld_addr    (ld_addr),
    .hit        (ld_hit),
    .data       (ld_data)
  );

endmodule

// File: tb/tb_mem_write_buffer.sv
// Self-checking bench for mem_write_buffer against a queue-based reference model.
module tb_mem_write_buffer;
  import mem_write_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          st_valid;
  logic [31:0]   st_pc;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_ready;
  logic          drain_en;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic [31:0]   dm_pc;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_din;
  logic          empty;
  logic          full;
  logic          overflow;

  always #5 clk = ~clk;

  mem_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_pc(st_pc), .st_addr(st_addr),
    .st_data(st_data), .st_ready(st_ready), .drain_en(drain_en), .ld_addr(ld_addr),
    .ld_hit(ld_hit), .ld_data(ld_data), .dm_pc(dm_pc), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_din(dm_din), .empty(empty), .full(full), .overflow(overflow)
  );

  wb_entry_t q[$];
  wb_entry_t exp_log[$];
  wb_entry_t dm_log[$];
  bit        m_ovf;
  int        checks = 0;
  int        errors = 0;

  // Record every write that DM actually captures.
  always @(posedge clk) begin
    if (!reset && dm_we) dm_log.push_back(wb_entry_t'{pc: dm_pc, addr: dm_addr, data: dm_din});
  end

  function automatic bit m_hit(input logic [AW-1:0] a);
    foreach (q[i]) if (q[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] m_ldata(input logic [AW-1:0] a);
    logic [DW-1:0] r = '0;
    foreach (q[i]) if (q[i].addr == a) r = q[i].data;
    return r;
  endfunction

  task automatic apply(input logic sv, input logic [31:0] pc, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic de, input logic [AW-1:0] la);
    st_valid = sv; st_pc = pc; st_addr = a; st_data = d; drain_en = de; ld_addr = la;
    #1;
  endtask

  // Advance one edge and update the reference model from the inputs seen at that edge.
  task automatic tick();
    bit fl;
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      fl = (q.size() == DEPTH);
      if (st_valid && fl) m_ovf = 1'b1;
      if (drain_en && q.size() > 0) begin
        exp_log.push_back(q[0]);
        void'(q.pop_front());
      end
      if (st_valid && !fl) q.push_back(wb_entry_t'{pc: st_pc, addr: st_addr, data: st_data});
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    apply(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    apply(0, 0, 0, 0, 1, 0);
    checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0)     begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready got %b exp 1", st_ready); end
    checks++; if (dm_we !== 1'b0)    begin errors++; $display("FAIL reset_dm_we got %b exp 0", dm_we); end
    checks++; if (ld_hit !== 1'b0 || ld_data !== '0)
      begin errors++; $display("FAIL reset_ld got hit=%b data=%h exp 0/0", ld_hit, ld_data); end
    checks++; if (dm_pc !== '0 || dm_addr !== '0 || dm_din !== '0)
      begin errors++; $display("FAIL reset_dm_bus got %h/%h/%h exp 0", dm_pc, dm_addr, dm_din); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    reset = 1'b0;
    q.delete(); m_ovf = 1'b0;
    apply(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_single();
    apply(1, 32'h3000, 10'h004, 32'h11223344, 0, 10'h004);
    checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL single_nofwd_push got %b exp 0", ld_hit); end
    tick();
    apply(0, 0, 0, 0, 0, 10'h004);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty got %b exp 0", empty); end
    checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h11223344)
      begin errors++; $display("FAIL single_fwd got %b/%h exp 1/11223344", ld_hit, ld_data); end
    checks++; if (dm_we !== 1'b0 || dm_pc !== 32'h3000 || dm_addr !== 10'h004)
      begin errors++; $display("FAIL single_head got we=%b pc=%h a=%h exp 0/3000/004", dm_we, dm_pc, dm_addr); end
    apply(0, 0, 0, 0, 1, 10'h004);
    checks++; if (dm_we !== 1'b1 || dm_addr !== 10'h004 || dm_din !== 32'h11223344)
      begin errors++; $display("FAIL single_drain got %b/%h/%h exp 1/004/11223344", dm_we, dm_addr, dm_din); end
    tick();
    apply(0, 0, 0, 0, 0, 10'h004);
    checks++; if (empty !== 1'b1 || dm_we !== 1'b0 || ld_hit !== 1'b0 || dm_addr !== '0)
      begin errors++; $display("FAIL single_after got e=%b we=%b hit=%b a=%h exp 1/0/0/0", empty, dm_we, ld_hit, dm_addr); end
    exp_log.delete(); dm_log.delete();
  endtask

  task automatic test_full_overflow();
    for (int i = 1; i <= 4; i++) begin
      apply(1, 32'h100 + i, AW'(i), 32'hA0 + i, 0, 0);
      tick();
    end
    apply(0, 0, 0, 0, 0, 0);
    checks++; if (full !== 1'b1 || st_ready !== 1'b0 || overflow !== 1'b0)
      begin errors++; $display("FAIL full_flags got f=%b r=%b o=%b exp 1/0/0", full, st_ready, overflow); end
    apply(1, 32'h200, 10'h005, 32'hDEAD, 0, 10'h005);
    tick();
    apply(0, 0, 0, 0, 0, 10'h005);
    checks++; if (overflow !== 1'b1 || ld_hit !== 1'b0 || full !== 1'b1)
      begin errors++; $display("FAIL full_drop got o=%b hit=%b f=%b exp 1/0/1", overflow, ld_hit, full); end
    for (int i = 1; i <= 4; i++) begin
      apply(0, 0, 0, 0, 1, 0);
      checks++; if (dm_we !== 1'b1 || dm_addr !== AW'(i))
        begin errors++; $display("FAIL full_order got we=%b a=%h exp 1/%h", dm_we, dm_addr, AW'(i)); end
      tick();
    end
    apply(0, 0, 0, 0, 0, 0);
    checks++; if (empty !== 1'b1 || overflow !== 1'b1)
      begin errors++; $display("FAIL full_end got e=%b o=%b exp 1/1", empty, overflow); end
    checks++; if (dm_log.size() != exp_log.size())
      begin errors++; $display("FAIL full_log_len got %0d exp %0d", dm_log.size(), exp_log.size()); end
    foreach (exp_log[i]) if (i < dm_log.size()) begin
      checks++; if (dm_log[i] !== exp_log[i])
        begin errors++; $display("FAIL full_log[%0d] got %h exp %h", i, dm_log[i], exp_log[i]); end
    end
    exp_log.delete(); dm_log.delete();
  endtask

  task automatic test_forward_dup();
    apply(1, 32'h500, 10'h010, 32'hA, 0, 10'h010);
    tick();
    apply(1, 32'h504, 10'h010, 32'hB, 0, 10'h010);
    checks++; if (ld_data !== 32'hA) begin errors++; $display("FAIL dup_old got %h exp a", ld_data); end
    tick();
    apply(0, 0, 0, 0, 0, 10'h010);
    checks++; if (ld_hit !== 1'b1 || ld_data !== 32'hB)
      begin errors++; $display("FAIL dup_young got %b/%h exp 1/b", ld_hit, ld_data); end
    apply(0, 0, 0, 0, 1, 10'h010);
    tick();
    apply(0, 0, 0, 0, 1, 10'h010);
    checks++; if (ld_hit !== 1'b1 || ld_data !== 32'hB)
      begin errors++; $display("FAIL dup_draining got %b/%h exp 1/b", ld_hit, ld_data); end
    tick();
    apply(0, 0, 0, 0, 0, 10'h010);
    checks++; if (ld_hit !== 1'b0 || ld_data !== '0)
      begin errors++; $display("FAIL dup_gone got %b/%h exp 0/0", ld_hit, ld_data); end
    exp_log.delete(); dm_log.delete();
  endtask

  task automatic test_back_to_back();
    apply(1, 32'h600, 10'h041, 32'd1, 0, 0);
    tick();
    for (int i = 2; i <= 8; i++) begin
      apply(1, 32'h600 + 4 * i, AW'(10'h040 + i), DW'(i), 1, AW'(10'h040 + i - 1));
      checks++; if (dm_we !== 1'b1 || dm_din !== DW'(i - 1) || empty !== 1'b0 || full !== 1'b0)
        begin errors++; $display("FAIL b2b_cycle%0d got we=%b d=%h e=%b f=%b exp 1/%h/0/0", i, dm_we, dm_din, empty, full, DW'(i - 1)); end
      checks++; if (ld_hit !== 1'b1 || ld_data !== DW'(i - 1))
        begin errors++; $display("FAIL b2b_fwd%0d got %b/%h exp 1/%h", i, ld_hit, ld_data, DW'(i - 1)); end
      tick();
    end
    checks++; if (dm_log.size() != 7) begin errors++; $display("FAIL b2b_log_len got %0d exp 7", dm_log.size()); end
    foreach (dm_log[k]) begin
      checks++; if (dm_log[k].data !== DW'(k + 1))
        begin errors++; $display("FAIL b2b_log[%0d] got %h exp %h", k, dm_log[k].data, DW'(k + 1)); end
    end
    apply(0, 0, 0, 0, 1, 0);
    tick();
    exp_log.delete(); dm_log.delete();
  endtask

  task automatic test_same_cycle_fwd();
    apply(1, 32'h700, 10'h020, 32'h55, 0, 10'h020);
    checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL same_cycle got %b exp 0", ld_hit); end
    tick();
    apply(0, 0, 0, 0, 0, 10'h020);
    checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h55)
      begin errors++; $display("FAIL next_cycle got %b/%h exp 1/55", ld_hit, ld_data); end
    apply(0, 0, 0, 0, 1, 0);
    tick();
    exp_log.delete(); dm_log.delete();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      apply(1, 32'h800 + i, AW'(10'h060 + i), DW'(32'hC0 + i), 0, 0);
      tick();
    end
    apply(0, 0, 0, 0, 1, 0);
    checks++; if (dm_we !== 1'b1) begin errors++; $display("FAIL rmid_pre got %b exp 1", dm_we); end
    reset = 1'b1;
    #1;
    checks++; if (dm_we !== 1'b0 || empty !== 1'b1 || overflow !== 1'b0)
      begin errors++; $display("FAIL rmid_async got we=%b e=%b o=%b exp 0/1/0", dm_we, empty, overflow); end
    tick();
    reset = 1'b0;
    repeat (3) begin
      apply(0, 0, 0, 0, 1, 0);
      tick();
    end
    checks++; if (dm_log.size() != 0 || empty !== 1'b1)
      begin errors++; $display("FAIL rmid_after got writes=%0d e=%b exp 0/1", dm_log.size(), empty); end
    exp_log.delete(); dm_log.delete();
  endtask

  task automatic test_random();
    logic          sv, de;
    logic [AW-1:0] a, la;
    logic          e_empty, e_full, e_we;
    wb_entry_t     e_head;
    for (int n = 0; n < 400; n++) begin
      sv = ($urandom_range(0, 9) < 6);
      de = ($urandom_range(0, 1) == 1);
      a  = AW'($urandom_range(0, 7));
      la = AW'($urandom_range(0, 7));
      apply(sv, $urandom, a, $urandom, de, la);
      e_empty = (q.size() == 0);
      e_full  = (q.size() == DEPTH);
      e_we    = de && !e_empty;
      e_head  = e_empty ? '0 : q[0];
      checks++; if (empty !== e_empty || full !== e_full || st_ready !== !e_full)
        begin errors++; $display("FAIL rnd_status n=%0d got e=%b f=%b r=%b exp %b/%b/%b", n, empty, full, st_ready, e_empty, e_full, !e_full); end
      checks++; if (dm_we !== e_we || dm_pc !== e_head.pc || dm_addr !== e_head.addr || dm_din !== e_head.data)
        begin errors++; $display("FAIL rnd_dm n=%0d got %b/%h/%h/%h exp %b/%h", n, dm_we, dm_pc, dm_addr, dm_din, e_we, e_head); end
      checks++; if (ld_hit !== m_hit(la) || ld_data !== m_ldata(la))
        begin errors++; $display("FAIL rnd_fwd n=%0d got %b/%h exp %b/%h", n, ld_hit, ld_data, m_hit(la), m_ldata(la)); end
      checks++; if (overflow !== m_ovf)
        begin errors++; $display("FAIL rnd_overflow n=%0d got %b exp %b", n, overflow, m_ovf); end
      tick();
    end
    checks++; if (dm_log.size() != exp_log.size())
      begin errors++; $display("FAIL rnd_log_len got %0d exp %0d", dm_log.size(), exp_log.size()); end
    foreach (exp_log[i]) if (i < dm_log.size()) begin
      checks++; if (dm_log[i] !== exp_log[i])
        begin errors++; $display("FAIL rnd_log[%0d] got %h exp %h", i, dm_log[i], exp_log[i]); end
    end
    exp_log.delete(); dm_log.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_overflow();
    test_forward_dup();
    test_back_to_back();
    test_same_cycle_fwd();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
